// File: rtl/spi_regbank.sv
// spi_regbank: serial slave giving a host write access to a bank of output words
// and read access to a bank of input words over a CEB-framed, MSB-first link.
// Frame layout (edge index n, counted from the first rising CLK with CEB low):
//   n=0 write flag, n=1 read flag, n=2..AW+1 address, n=AW+2..AW+sword+1 write data,
//   n=AW+sword+2..AW+2*sword+1 read window shifted out on DOUT.
module spi_regbank #(
  parameter int unsigned registers = 8,
  parameter int unsigned inputs    = 6,
  parameter int unsigned sword     = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CEB,
  input  logic                        DATA,
  output logic                        DOUT,
  output logic [sword*registers-1:0]  R,
  input  logic [sword*inputs-1:0]     RD
);

  localparam int unsigned MaxWords = (registers > inputs) ? registers : inputs;
  localparam int unsigned AW       = ($clog2(MaxWords) < 1) ? 1 : $clog2(MaxWords);

  // Edge indices of the frame phases.
  localparam int unsigned AddrFirst = 2;
  localparam int unsigned AddrLast  = AW + 1;
  localparam int unsigned DataFirst = AW + 2;
  localparam int unsigned DataLast  = AW + sword + 1;
  localparam int unsigned ReadFirst = AW + sword + 2;
  localparam int unsigned ReadLast  = AW + 2 * sword + 1;
  // Counter parks here once the frame is complete until CEB rises.
  localparam int unsigned Sat       = ReadLast + 1;
  localparam int unsigned CW        = $clog2(Sat + 1);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       w_q, w_d;
  logic                       rd_q, rd_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [sword-1:0]           data_q, data_d;
  logic [sword-1:0]           rsh_q, rsh_d;
  logic                       dout_q, dout_d;
  logic [sword*registers-1:0] r_q, r_d;

  // Phase decode of the current edge index.
  logic ph_w, ph_rd, ph_addr, ph_data, ph_commit, ph_rfirst, ph_rshift;

  always_comb begin
    ph_w      = (cnt_q == CW'(0));
    ph_rd     = (cnt_q == CW'(1));
    ph_addr   = (cnt_q >= CW'(AddrFirst)) && (cnt_q <= CW'(AddrLast));
    ph_data   = (cnt_q >= CW'(DataFirst)) && (cnt_q <= CW'(DataLast));
    ph_commit = (cnt_q == CW'(DataLast));
    ph_rfirst = (cnt_q == CW'(ReadFirst));
    ph_rshift = (cnt_q > CW'(ReadFirst)) && (cnt_q <= CW'(ReadLast));
  end

  // Shifted-in views of the address and data registers with the current DATA bit.
  logic [AW:0]      addr_ext;
  logic [sword:0]   data_ext;
  logic [sword-1:0] wdata;

  always_comb begin
    addr_ext = {addr_q, DATA};
    data_ext = {data_q, DATA};
    wdata    = data_ext[sword-1:0];
  end

  // Addressed input word; zero when reads are disabled or the address is out of range.
  logic [sword-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    if (rd_q) begin
      for (int i = 0; i < int'(inputs); i++) begin
        if (int'(addr_q) == i) rd_sel = RD[sword*i +: sword];
      end
    end
  end

  // Next-state logic for the frame counter, captured fields, write commit and read shifter.
  always_comb begin
    cnt_d  = cnt_q;
    w_d    = w_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    data_d = data_q;
    rsh_d  = rsh_q;
    dout_d = 1'b0;
    r_d    = r_q;

    if (CEB) begin
      // Idle or abort: drop all frame state, outputs other than DOUT hold.
      cnt_d  = '0;
      w_d    = 1'b0;
      rd_d   = 1'b0;
      addr_d = '0;
      data_d = '0;
      rsh_d  = '0;
    end else begin
      if (cnt_q != CW'(Sat)) cnt_d = cnt_q + CW'(1);

      if (ph_w)    w_d    = DATA;
      if (ph_rd)   rd_d   = DATA;
      if (ph_addr) addr_d = addr_ext[AW-1:0];
      if (ph_data) data_d = wdata;

      // Out-of-range addresses match no word, so they write nothing.
      if (ph_commit && w_q) begin
        for (int i = 0; i < int'(registers); i++) begin
          if (int'(addr_q) == i) r_d[sword*i +: sword] = wdata;
        end
      end

      if (ph_rfirst) begin
        dout_d = rd_sel[sword-1];
        rsh_d  = rd_sel << 1;
      end else if (ph_rshift) begin
        dout_d = rsh_q[sword-1];
        rsh_d  = rsh_q << 1;
      end
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      w_q    <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      rsh_q  <= '0;
      dout_q <= 1'b0;
      r_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      w_q    <= w_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rsh_q  <= rsh_d;
      dout_q <= dout_d;
      r_q    <= r_d;
    end
  end

  assign DOUT = dout_q;
  assign R    = r_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Testbench for spi_regbank: table of directed frames plus hand-written abort,
// saturation and mid-frame reset sequences.
module tb_spi_regbank;

  localparam int unsigned Regs  = 8;
  localparam int unsigned Ins   = 6;
  localparam int unsigned Sword = 8;

  logic                    clk;
  logic                    rst;
  logic                    ceb;
  logic                    din;
  logic                    dout;
  logic [Sword*Regs-1:0]   r;
  logic [Sword*Ins-1:0]    rd;

  int n_cmp;
  int n_bad;

  logic [7:0] shadow [Regs];

  spi_regbank #(
    .registers(Regs),
    .inputs   (Ins),
    .sword    (Sword)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .CEB (ceb),
    .DATA(din),
    .DOUT(dout),
    .R   (r),
    .RD  (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       rdf;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp_r;
    logic [7:0] exp_dout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bank(input string name);
    logic [63:0] exp;
    for (int i = 0; i < int'(Regs); i++) exp[8*i +: 8] = shadow[i];
    check(name, r, exp);
  endtask

  // One rising edge with CEB low and DATA=b; returns 1 ns after the edge.
  task automatic clock_bit(input logic b);
    @(negedge clk);
    ceb = 1'b0;
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    @(negedge clk);
    ceb = 1'b1;
    din = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs nedges edges of a frame; collects the read window and counts DOUT=1 outside it.
  task automatic frame(input logic w, input logic rdf, input logic [2:0] addr,
                       input logic [7:0] data, input int nedges, input logic extra,
                       output logic [7:0] rdat, output int noise);
    logic [12:0] hdr;
    hdr   = {w, rdf, addr, data};
    rdat  = '0;
    noise = 0;
    for (int e = 0; e < nedges; e++) begin
      if (e < 13)      clock_bit(hdr[12-e]);
      else if (e < 21) clock_bit(1'b0);
      else             clock_bit(extra);
      if (e >= 13 && e < 21) rdat = {rdat[6:0], dout};
      else if (dout !== 1'b0) noise++;
    end
  endtask

  vec_t vecs [12];

  initial begin
    logic [7:0] rdat;
    int         noise;
    logic [7:0] r1_before;

    n_cmp = 0;
    n_bad = 0;
    for (int k = 0; k < int'(Ins); k++) rd[8*k +: 8] = 8'(k);
    for (int i = 0; i < int'(Regs); i++) shadow[i] = 8'h00;

    vecs[0]  = '{w:1'b1, rdf:1'b1, addr:3'd3, data:8'hA5, exp_r:8'hA5, exp_dout:8'h03};
    vecs[1]  = '{w:1'b1, rdf:1'b1, addr:3'd0, data:8'hA0, exp_r:8'hA0, exp_dout:8'h00};
    vecs[2]  = '{w:1'b1, rdf:1'b1, addr:3'd1, data:8'hA1, exp_r:8'hA1, exp_dout:8'h01};
    vecs[3]  = '{w:1'b1, rdf:1'b1, addr:3'd2, data:8'hA2, exp_r:8'hA2, exp_dout:8'h02};
    vecs[4]  = '{w:1'b1, rdf:1'b1, addr:3'd3, data:8'hA3, exp_r:8'hA3, exp_dout:8'h03};
    vecs[5]  = '{w:1'b1, rdf:1'b1, addr:3'd4, data:8'hA4, exp_r:8'hA4, exp_dout:8'h04};
    vecs[6]  = '{w:1'b1, rdf:1'b1, addr:3'd5, data:8'hA5, exp_r:8'hA5, exp_dout:8'h05};
    vecs[7]  = '{w:1'b1, rdf:1'b1, addr:3'd6, data:8'hA6, exp_r:8'hA6, exp_dout:8'h00};
    vecs[8]  = '{w:1'b1, rdf:1'b1, addr:3'd7, data:8'hA7, exp_r:8'hA7, exp_dout:8'h00};
    vecs[9]  = '{w:1'b0, rdf:1'b1, addr:3'd2, data:8'hFF, exp_r:8'hA2, exp_dout:8'h02};
    vecs[10] = '{w:1'b1, rdf:1'b0, addr:3'd4, data:8'h3C, exp_r:8'h3C, exp_dout:8'h00};
    vecs[11] = '{w:1'b1, rdf:1'b1, addr:3'd7, data:8'h55, exp_r:8'h55, exp_dout:8'h00};

    // Reset state.
    rst = 1'b1;
    ceb = 1'b1;
    din = 1'b0;
    #1;
    check("reset_r", r, 64'h0);
    check("reset_dout", {63'h0, dout}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    end_frame();

    // Table-driven frames.
    for (int v = 0; v < 12; v++) begin
      frame(vecs[v].w, vecs[v].rdf, vecs[v].addr, vecs[v].data, 21, 1'b0, rdat, noise);
      end_frame();
      shadow[vecs[v].addr] = vecs[v].exp_r;
      check($sformatf("vec%0d_r_word", v), r[8*vecs[v].addr +: 8], vecs[v].exp_r);
      check($sformatf("vec%0d_dout", v), rdat, vecs[v].exp_dout);
      check($sformatf("vec%0d_dout_quiet", v), noise, 0);
      check_bank($sformatf("vec%0d_bank", v));
      check($sformatf("vec%0d_dout_idle", v), {63'h0, dout}, 64'h0);
    end

    // Isolation: word 7 holds 0x55, now write word 0.
    frame(1'b1, 1'b0, 3'd0, 8'hFF, 21, 1'b0, rdat, noise);
    end_frame();
    shadow[0] = 8'hFF;
    check_bank("isolation_bank");
    check("isolation_word7", r[8*7 +: 8], 8'h55);

    // Abort after 4 of 8 data bits: nothing written.
    r1_before = shadow[1];
    frame(1'b1, 1'b0, 3'd1, 8'h3C, 9, 1'b0, rdat, noise);
    end_frame();
    check("abort_word1", r[8*1 +: 8], r1_before);
    check_bank("abort_bank");
    frame(1'b1, 1'b1, 3'd1, 8'h3C, 21, 1'b0, rdat, noise);
    end_frame();
    shadow[1] = 8'h3C;
    check("after_abort_word1", r[8*1 +: 8], 8'h3C);
    check("after_abort_dout", rdat, 8'h01);

    // Saturation: extra edges with DATA=1 after the read window change nothing.
    frame(1'b1, 1'b1, 3'd5, 8'h77, 26, 1'b1, rdat, noise);
    shadow[5] = 8'h77;
    check("sat_dout_quiet", noise, 0);
    check("sat_dout", rdat, 8'h05);
    end_frame();
    check_bank("sat_bank");

    // Mid-frame reset during the read window while DOUT is high.
    frame(1'b0, 1'b1, 3'd5, 8'h00, 19, 1'b0, rdat, noise);
    check("pre_reset_dout", {63'h0, dout}, 64'h1);
    rst = 1'b1;
    #1;
    check("midreset_r", r, 64'h0);
    check("midreset_dout", {63'h0, dout}, 64'h0);
    ceb = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < int'(Regs); i++) shadow[i] = 8'h00;
    end_frame();
    frame(1'b1, 1'b1, 3'd6, 8'h99, 21, 1'b0, rdat, noise);
    end_frame();
    shadow[6] = 8'h99;
    check("post_reset_bank", r, {8'h00, 8'h99, 48'h0});
    check("post_reset_dout", rdat, 8'h00);
    frame(1'b0, 1'b1, 3'd4, 8'h00, 21, 1'b0, rdat, noise);
    end_frame();
    check("post_reset_read4", rdat, 8'h04);
    check_bank("post_reset_bank2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
